spi_regfile_peripheral: RTL and testbench

Parametrised SPI mode-0 register-file slave, successor to the fixed 5-register write-only SPI peripheral. All SPI inputs are oversampled in the fast `clk` domain. The block decodes a frame of 1 R/W bit, then ADDR_W address bits, then DATA_W data bits, all MSB first. It writes into NUM_REGS registers and, unlike its predecessor, supports read-back on CIPO. Its outputs feed the output-enable, PWM-enable and duty-cycle logic as one flat bus.

---
 rtl/spi_regfile_peripheral.sv | 183 ++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file slave with read-back; all SPI pins are oversampled in clk.
// Define SPI_AUTOINC_EN to enable burst mode (address auto-increment per extra data word).
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA0     = CNT_W'(1 + ADDR_W);
  localparam logic [ADDR_W:0]  NUM_REGS_W    = (ADDR_W+1)'(NUM_REGS);
`ifdef SPI_AUTOINC_EN
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME - 1);
`endif

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_active, copi_s;

  logic [CNT_W-1:0]  cnt;
  logic              rw;
  logic [ADDR_W-1:0] addr_sr, addr_shifted;
  logic [DATA_W-1:0] data_sr, data_shifted, rd_sr;
  logic [DATA_W-1:0] regs [NUM_REGS];

`ifdef SPI_AUTOINC_EN
  logic              burst_started, addr_ovf, ovf_next;
  logic [ADDR_W-1:0] addr_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '1;
      copi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sCLK};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
    end
  end

  // COPI is taken from the oldest stage; it is stable for half an sCLK period around the rise.
  assign sclk_rise    = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall    = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign ncs_rise     = ncs_sync[SYNC_STAGES-2] & ~ncs_sync[SYNC_STAGES-1];
  assign ncs_fall     = ~ncs_sync[SYNC_STAGES-2] & ncs_sync[SYNC_STAGES-1];
  assign ncs_active   = ~ncs_sync[SYNC_STAGES-2] & ~ncs_sync[SYNC_STAGES-1];
  assign copi_s       = copi_sync[SYNC_STAGES-1];
  assign addr_shifted = {addr_sr[ADDR_W-2:0], copi_s};
  assign data_shifted = {data_sr[DATA_W-2:0], copi_s};

`ifdef SPI_AUTOINC_EN
  assign addr_next = addr_sr + ADDR_W'(1);
  assign ovf_next  = addr_ovf | (&addr_sr);
`endif

  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) r = regs[i];
    return r;
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // nCS edges take priority over sCLK edges; a read loaded in a commit cycle sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rw        <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      CIPO      <= 1'b0;
      cipo_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef SPI_AUTOINC_EN
      burst_started <= 1'b0;
      addr_ovf      <= 1'b0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      cipo_oe   <= ~ncs_sync[SYNC_STAGES-2];
      if (ncs_fall) begin
        cnt     <= '0;
        rw      <= 1'b0;
        addr_sr <= '0;
        data_sr <= '0;
        rd_sr   <= '0;
        CIPO    <= 1'b0;
`ifdef SPI_AUTOINC_EN
        burst_started <= 1'b0;
        addr_ovf      <= 1'b0;
`endif
      end else if (ncs_rise) begin
        CIPO <= 1'b0;
`ifdef SPI_AUTOINC_EN
        if (cnt != '0 && !(cnt == CNT_DATA0 && burst_started)) frame_err <= 1'b1;
`else
        if (cnt == CNT_FRAME) begin
          if (rw && is_mapped(addr_sr)) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (addr_sr == ADDR_W'(i)) regs[i] <= data_sr;
            wr_strobe <= 1'b1;
            wr_addr   <= addr_sr;
          end
        end else if (cnt != '0) begin
          frame_err <= 1'b1;
        end
`endif
      end else if (ncs_active && sclk_rise) begin
        if (cnt == '0) begin
          rw  <= copi_s;
          cnt <= cnt + CNT_W'(1);
        end else if (cnt <= CNT_LAST_ADDR) begin
          addr_sr <= addr_shifted;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST_ADDR) rd_sr <= read_reg(addr_shifted);
`ifdef SPI_AUTOINC_EN
        end else begin
          data_sr <= data_shifted;
          if (cnt == CNT_LAST) begin
            // Word complete: commit it, step the address and preload the next read word.
            if (rw && !addr_ovf && is_mapped(addr_sr)) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (addr_sr == ADDR_W'(i)) regs[i] <= data_shifted;
              wr_strobe <= 1'b1;
              wr_addr   <= addr_sr;
            end
            burst_started <= 1'b1;
            addr_sr       <= addr_next;
            addr_ovf      <= ovf_next;
            rd_sr         <= ovf_next ? '0 : read_reg(addr_next);
            cnt           <= CNT_DATA0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`else
        end else if (cnt < CNT_FRAME) begin
          data_sr <= data_shifted;
          cnt     <= cnt + CNT_W'(1);
        end
`endif
      end else if (ncs_active && sclk_fall) begin
        if (!rw && cnt >= CNT_DATA0 && cnt < CNT_FRAME) begin
          CIPO  <= rd_sr[DATA_W-1];
          rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
        end else begin
          CIPO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: expected writes/aborts are queued at stimulus
// time and popped by a monitor on wr_strobe / frame_err; register and read-back checks are direct.
module tb_spi_regfile_peripheral;
  localparam int NUM_REGS    = 5;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
  logic cipo, cipo_oe, wr_strobe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [ADDR_W-1:0] wr_addr;

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sCLK(sclk), .nCS(ncs), .COPI(copi), .CIPO(cipo),
    .cipo_oe(cipo_oe), .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  int checks = 0;
  int fails  = 0;
  wr_exp_t wr_q[$];
  int err_q[$];
  logic [DATA_W-1:0] model [NUM_REGS];

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every strobe / abort pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_exp_t e;
    if (rst_n) begin
      if (wr_strobe) begin
        if (wr_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL wr_strobe: unexpected pulse with wr_addr 0x%0h, expected none", wr_addr);
        end else begin
          e = wr_q.pop_front();
          checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
          checkOutput("committed word", 64'(reg_q[int'(e.addr)*DATA_W +: DATA_W]), 64'(e.data));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL frame_err: unexpected pulse, expected none");
        end else begin
          void'(err_q.pop_front());
          checks++;
        end
      end
    end
  end

  task automatic sendBits(input logic [63:0] bits, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      #40;
      rx = {rx[62:0], cipo};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data, input int ndata,
                               output logic [31:0] rdata);
    logic [63:0] bits, rx, mask;
    mask = (64'd1 << ndata) - 64'd1;
    bits = ({56'd0, rw, addr} << ndata) | (64'(data) & mask);
    ncs = 1'b0;
    sendBits(bits, 1 + ADDR_W + ndata, rx);
    checkOutput("cipo_oe in frame", 64'(cipo_oe), 64'd1);
    #40;
    ncs = 1'b1;
    copi = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    @(negedge clk);
    rdata = 32'(rx & mask);
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] rx;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset reg_q", 64'(reg_q), 64'd0);
    checkOutput("reset CIPO", 64'(cipo), 64'd0);
    checkOutput("reset cipo_oe", 64'(cipo_oe), 64'd0);
    checkOutput("reset wr_strobe", 64'(wr_strobe), 64'd0);
    checkOutput("reset wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("reset frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] write 0xA5 to reg 2");
    wr_q.push_back('{addr: 7'd2, data: 8'hA5});
    model[2] = 8'hA5;
    applyStimulus(1'b1, 7'd2, 32'hA5, 8, rd);
    checkOutput("reg_q after write 2", 64'(reg_q), 64'(model_flat()));
    checkOutput("reg_q[23:16]", 64'(reg_q[23:16]), 64'hA5);
    checkOutput("cipo_oe idle", 64'(cipo_oe), 64'd0);

    $display("[TB] write 0x3C to reg 4 then read it back");
    wr_q.push_back('{addr: 7'd4, data: 8'h3C});
    model[4] = 8'h3C;
    applyStimulus(1'b1, 7'd4, 32'h3C, 8, rd);
    applyStimulus(1'b0, 7'd4, 32'h00, 8, rd);
    checkOutput("read reg 4", 64'(rd), 64'h3C);
    checkOutput("reg_q after read", 64'(reg_q), 64'(model_flat()));
    applyStimulus(1'b0, 7'd2, 32'hFF, 8, rd);
    checkOutput("read reg 2", 64'(rd), 64'hA5);
    checkOutput("CIPO after read", 64'(cipo), 64'd0);

    $display("[TB] unmapped address 5");
    applyStimulus(1'b1, 7'd5, 32'h99, 8, rd);
    checkOutput("reg_q after unmapped write", 64'(reg_q), 64'(model_flat()));
    applyStimulus(1'b0, 7'd5, 32'h00, 8, rd);
    checkOutput("read unmapped", 64'(rd), 64'h00);

    $display("[TB] aborted frame after 10 bits, then full write to reg 1");
    err_q.push_back(1);
    applyStimulus(1'b1, 7'd1, 32'h2, 2, rd);
    checkOutput("reg_q after abort", 64'(reg_q), 64'(model_flat()));
    wr_q.push_back('{addr: 7'd1, data: 8'h77});
    model[1] = 8'h77;
    applyStimulus(1'b1, 7'd1, 32'h77, 8, rd);
    checkOutput("reg_q after write 1", 64'(reg_q), 64'(model_flat()));

    $display("[TB] nCS toggle without clocks");
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("reg_q after empty frame", 64'(reg_q), 64'(model_flat()));

`ifndef SPI_AUTOINC_EN
    $display("[TB] extra sCLK edges beyond the frame");
    wr_q.push_back('{addr: 7'd0, data: 8'h12});
    model[0] = 8'h12;
    applyStimulus(1'b1, 7'd0, 32'h12F, 12, rd);
    checkOutput("reg_q after long frame", 64'(reg_q), 64'(model_flat()));
`else
    $display("[TB] burst write at reg 3");
    wr_q.push_back('{addr: 7'd3, data: 8'h11});
    wr_q.push_back('{addr: 7'd4, data: 8'h22});
    model[3] = 8'h11;
    model[4] = 8'h22;
    applyStimulus(1'b1, 7'd3, 32'h112233, 24, rd);
    checkOutput("reg_q after burst", 64'(reg_q), 64'(model_flat()));
    applyStimulus(1'b0, 7'd3, 32'h0, 24, rd);
    checkOutput("burst read", 64'(rd), 64'h112200);
`endif

    $display("[TB] reset asserted mid-frame");
    wr_q.push_back('{addr: 7'd3, data: 8'hFF});
    model[3] = 8'hFF;
    applyStimulus(1'b1, 7'd3, 32'hFF, 8, rd);
    checkOutput("reg_q before reset", 64'(reg_q), 64'(model_flat()));
    ncs = 1'b0;
    sendBits({52'd0, 1'b1, 7'd0, 4'hA}, 12, rx);
    rst_n = 1'b0;
    ncs = 1'b1;
    copi = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    checkOutput("reg_q in reset", 64'(reg_q), 64'd0);
    checkOutput("wr_strobe in reset", 64'(wr_strobe), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wr_q.push_back('{addr: 7'd0, data: 8'h5A});
    model[0] = 8'h5A;
    applyStimulus(1'b1, 7'd0, 32'h5A, 8, rd);
    checkOutput("reg_q after fresh frame", 64'(reg_q), 64'(model_flat()));

    repeat (5) @(negedge clk);
    checkOutput("pending writes", 64'(wr_q.size()), 64'd0);
    checkOutput("pending aborts", 64'(err_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
